// File: rtl/bcd_autorange_latch_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | freq_disp_pkg : shared constants, FSM states and BCD helper  (rev 1.0)    |
// +---------------------------------------------------------------------------+
package freq_disp_pkg;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;
  localparam int         ENG_GROUP   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    LOAD = 2'd2
  } state_t;

  function automatic logic bcd_is_valid(input logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_autorange_latch_window_select.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | window_select : display window, blanking and engineering dp  (rev 1.0)    |
// +---------------------------------------------------------------------------+
module window_select
  import freq_disp_pkg::*;
#(
  parameter int IN_DIGITS  = 6,
  parameter int OUT_DIGITS = 4,
  parameter int SHIFT_W    = 2,
  parameter int UNIT_W     = 2,
  parameter int CNT_W      = 3
) (
  input  logic [IN_DIGITS*4-1:0]  snap,
  input  logic [CNT_W-1:0]        msd,
  input  logic                    err_in,
  output logic [OUT_DIGITS*4-1:0] win_digits,
  output logic [OUT_DIGITS-1:0]   win_dp,
  output logic [UNIT_W-1:0]       win_unit,
  output logic [SHIFT_W-1:0]      win_shift,
  output logic                    win_err
);

  localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(OUT_DIGITS - 1);

  logic [CNT_W-1:0]       s;
  logic [CNT_W-1:0]       rel;
  logic [IN_DIGITS*4-1:0] shifted;
  int                     s_int;
  int                     rem;
  int                     j_dp;

  // Window is right-aligned to the count until the MSD would fall off the top.
  assign s         = (msd > TOP_IDX) ? msd - TOP_IDX : '0;
  assign rel       = msd - s;
  assign shifted   = snap >> {s, 2'b00};
  assign win_shift = SHIFT_W'(s);
  assign win_err   = err_in;

  for (genvar j = 0; j < OUT_DIGITS; j++) begin : g_digit
    if (j == 0) begin : g_lsd
      assign win_digits[3:0] = shifted[3:0];
    end else begin : g_upper
      assign win_digits[4*j +: 4] = (CNT_W'(j) > rel) ? BLANK_DIGIT : shifted[4*j +: 4];
    end
  end

  // The point goes on the first engineering boundary above window digit 0.
  always_comb begin
    s_int    = int'(s);
    rem      = s_int % ENG_GROUP;
    j_dp     = (rem == 0) ? ENG_GROUP : ENG_GROUP - rem;
    win_dp   = '0;
    win_unit = '0;
    if (int'(msd) >= ENG_GROUP) begin
      win_dp   = OUT_DIGITS'(1) << j_dp;
      win_unit = UNIT_W'((s_int + j_dp) / ENG_GROUP);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_autorange_latch.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | bcd_autorange_latch : snapshot, MSD scan and autoranged display latch     |
// | rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module bcd_autorange_latch
  import freq_disp_pkg::*;
#(
  parameter int IN_DIGITS  = 6,
  parameter int OUT_DIGITS = 4,
  parameter int SHIFT_W    = 2,
  parameter int UNIT_W     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    latch_req,
  input  logic [IN_DIGITS*4-1:0]  digits_in,
  output logic [OUT_DIGITS*4-1:0] disp_digits,
  output logic [OUT_DIGITS-1:0]   disp_dp,
  output logic [UNIT_W-1:0]       unit,
  output logic [SHIFT_W-1:0]      shift,
  output logic                    err,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = (IN_DIGITS > 1) ? $clog2(IN_DIGITS) : 1;

  state_t                  state;
  logic                    prev_req;
  logic                    pending;
  logic                    found;
  logic                    err_acc;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        msd;
  logic [IN_DIGITS*4-1:0]  snap;
  logic [IN_DIGITS*4-1:0]  snap_sh;
  logic [3:0]              cur_digit;
  logic                    req;

  logic [OUT_DIGITS*4-1:0] sel_digits;
  logic [OUT_DIGITS-1:0]   sel_dp;
  logic [UNIT_W-1:0]       sel_unit;
  logic [SHIFT_W-1:0]      sel_shift;
  logic                    sel_err;

  assign req       = latch_req & ~prev_req;
  assign snap_sh   = snap >> {cnt, 2'b00};
  assign cur_digit = snap_sh[3:0];

  window_select #(
    .IN_DIGITS (IN_DIGITS),
    .OUT_DIGITS(OUT_DIGITS),
    .SHIFT_W   (SHIFT_W),
    .UNIT_W    (UNIT_W),
    .CNT_W     (CNT_W)
  ) u_window_select (
    .snap      (snap),
    .msd       (msd),
    .err_in    (err_acc),
    .win_digits(sel_digits),
    .win_dp    (sel_dp),
    .win_unit  (sel_unit),
    .win_shift (sel_shift),
    .win_err   (sel_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prev_req    <= 1'b0;
      pending     <= 1'b0;
      found       <= 1'b0;
      err_acc     <= 1'b0;
      cnt         <= '0;
      msd         <= '0;
      snap        <= '0;
      disp_digits <= {OUT_DIGITS{BLANK_DIGIT}};
      disp_dp     <= '0;
      unit        <= '0;
      shift       <= '0;
      err         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      prev_req <= latch_req;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (req || pending) begin
            snap    <= digits_in;
            cnt     <= CNT_W'(IN_DIGITS - 1);
            msd     <= '0;
            found   <= 1'b0;
            err_acc <= 1'b0;
            pending <= 1'b0;
            busy    <= 1'b1;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (req) pending <= 1'b1;
          // Scanning downward, so the first non-zero digit hit is the MSD.
          if (cur_digit != 4'd0 && !found) begin
            msd   <= cnt;
            found <= 1'b1;
          end
          if (!bcd_is_valid(cur_digit)) err_acc <= 1'b1;
          if (cnt == '0) state <= LOAD;
          else           cnt   <= cnt - 1'b1;
        end
        LOAD: begin
          if (req) pending <= 1'b1;
          disp_digits <= sel_digits;
          disp_dp     <= sel_dp;
          unit        <= sel_unit;
          shift       <= sel_shift;
          err         <= sel_err;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
